// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: FIFO read port plus the downstream valid/ready stream.
// The master modport is the reader's view; slave is the FIFO/sink side.
interface fifo_rd_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_r_en;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    modport master (
        input  fifo_empty, fifo_data, m_ready,
        output fifo_r_en, m_valid, m_data
    );
    modport slave (
        output fifo_empty, fifo_data, m_ready,
        input  fifo_r_en, m_valid, m_data
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: rclk-domain FIFO reader feeding a 2-entry elastic buffer and a valid/ready stream.
// Defining RD_STREAM_STATS_EN adds saturating xfer_cnt/stall_cnt outputs.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input logic              rclk,
    input logic              rrst_n,
    fifo_rd_stream_if.master bus
`ifdef RD_STREAM_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] xfer_cnt,
    output logic [CNT_WIDTH-1:0] stall_cnt
`endif
);
    logic [DATA_WIDTH-1:0] mem_q [2];
    logic                  head_q, head_d, tail_q, tail_d, pend_q, pend_d, pop;
    logic [1:0]            occ_q, occ_d;
    logic [2:0]            lvl;
    // lvl is the buffer fill after this edge if no new read is issued; read only while room remains
    always_comb begin
        pop    = (occ_q != 2'd0) && bus.m_ready;
        lvl    = {1'b0, occ_q} + {2'b0, pend_q} - {2'b0, pop};
        pend_d = rrst_n && !bus.fifo_empty && (lvl <= 3'd1);
        head_d = head_q ^ pop;
        tail_d = tail_q ^ pend_q;
        occ_d  = occ_q + {1'b0, pend_q} - {1'b0, pop};
    end
    assign bus.fifo_r_en = pend_d;
    assign bus.m_valid   = occ_q != 2'd0;
    assign bus.m_data    = mem_q[head_q];
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            mem_q  <= '{default: '0};
            head_q <= 1'b0;
            tail_q <= 1'b0;
            pend_q <= 1'b0;
            occ_q  <= 2'd0;
        end else begin
            if (pend_q) mem_q[tail_q] <= bus.fifo_data;
            head_q <= head_d;
            tail_q <= tail_d;
            pend_q <= pend_d;
            occ_q  <= occ_d;
        end
    end
`ifdef RD_STREAM_STATS_EN
    logic [CNT_WIDTH-1:0] xfer_q, stall_q;
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            xfer_q  <= '0;
            stall_q <= '0;
        end else begin
            if (pop && !(&xfer_q)) xfer_q <= xfer_q + CNT_WIDTH'(1);
            if (bus.m_valid && !bus.m_ready && !(&stall_q)) stall_q <= stall_q + CNT_WIDTH'(1);
        end
    end
    assign xfer_cnt  = xfer_q;
    assign stall_cnt = stall_q;
`else
    if (CNT_WIDTH < 1) begin : g_cnt_width_check
        $error("CNT_WIDTH must be at least 1");
    end
`endif
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: drives a queue-backed FIFO model and checks the stream against the read order.
// Stats checks are compiled in when RD_STREAM_STATS_EN is defined.
module tb_fifo_rd_stream;
    localparam int DW = 8;
`ifdef RD_STREAM_STATS_EN
    localparam int CW = 4;
    logic [CW-1:0] xfer_cnt, stall_cnt;
`else
    localparam int CW = 16;
`endif
    logic rclk = 1'b0;
    logic rrst_n = 1'b0;
    fifo_rd_stream_if #(.DATA_WIDTH(DW)) bus ();
    fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .rclk(rclk),
        .rrst_n(rrst_n),
        .bus(bus)
`ifdef RD_STREAM_STATS_EN
        ,
        .xfer_cnt(xfer_cnt),
        .stall_cnt(stall_cnt)
`endif
    );
    always #5 rclk = ~rclk;

    typedef struct {
        bit            emp;
        bit            rdy;
        bit            re;
        bit            v;
        logic [DW-1:0] d;
    } vec_t;
    vec_t vec [11];

    int            n_chk, n_fail, inflight, npop, nread, stalls, xfers;
    logic [DW-1:0] src [$];
    logic [DW-1:0] exp_q [$];
    bit            prev_v, prev_pop, s_re, s_v;
    logic [DW-1:0] prev_d, s_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit gate, input bit rdy);
        bus.fifo_empty = (src.size() == 0) || gate;
        bus.m_ready    = rdy;
    endtask

    // One rclk cycle: sample mid-cycle, update the model, then move to just after the edge.
    task automatic step();
        logic [DW-1:0] w;
        bit            pop;
        #4;
        s_re = bus.fifo_r_en;
        s_v  = bus.m_valid;
        s_d  = bus.m_data;
        pop  = s_v && bus.m_ready;
        if (prev_v && !prev_pop) begin
            chk("hold_valid", s_v, 1);
            chk("hold_data", s_d, prev_d);
        end
        if (s_re) chk("r_en_while_empty", bus.fifo_empty, 0);
        if (s_v && !bus.m_ready) stalls++;
        if (pop) begin
            chk("pop_has_word", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("order", s_d, exp_q.pop_front());
            npop++;
            xfers++;
            inflight--;
        end
        if (s_re) begin
            w = (src.size() != 0) ? src.pop_front() : DW'($urandom);
            exp_q.push_back(w);
            inflight++;
            nread++;
        end
        chk("in_flight_le_2", inflight <= 2, 1);
        prev_v   = s_v;
        prev_pop = pop;
        prev_d   = s_d;
        @(posedge rclk);
        #1;
        bus.fifo_data = s_re ? w : DW'($urandom);
    endtask

    task automatic do_reset();
        #2 rrst_n = 1'b0;
        #1;
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_r_en", bus.fifo_r_en, 0);
        chk("rst_m_data", bus.m_data, 0);
        src.delete();
        exp_q.delete();
        inflight       = 0;
        prev_v         = 0;
        prev_pop       = 0;
        stalls         = 0;
        xfers          = 0;
        bus.fifo_empty = 1'b1;
        @(posedge rclk);
        #1 rrst_n = 1'b1;
    endtask

    task automatic run_until(input int target, input int budget, input bit rnd);
        int p0 = npop;
        int c  = 0;
        while (npop - p0 < target && c < budget) begin
            drive(rnd ? ($urandom_range(3) == 0) : 1'b0, rnd ? 1'($urandom_range(1)) : 1'b1);
            step();
            c++;
        end
        chk("pop_count", npop - p0, target);
    endtask

    initial begin
        int r0;
        for (int i = 0; i < 11; i++)
            vec[i] = '{emp: i >= 8, rdy: 1'b1, re: i < 8, v: i >= 2 && i < 10, d: DW'(8'h10 + i - 2)};
        bus.fifo_empty = 1'b1;
        bus.m_ready    = 1'b1;
        bus.fifo_data  = '0;
        do_reset();
        // idle after reset
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1);
            step();
            chk("idle_r_en", s_re, 0);
            chk("idle_m_valid", s_v, 0);
            chk("idle_m_data", s_d, 0);
        end
        // full-rate streaming of 0x10..0x17
        for (int i = 0; i < 8; i++) src.push_back(DW'(8'h10 + i));
        for (int i = 0; i < 11; i++) begin
            bus.fifo_empty = vec[i].emp;
            bus.m_ready    = vec[i].rdy;
            step();
            chk("tbl_r_en", s_re, vec[i].re);
            chk("tbl_m_valid", s_v, vec[i].v);
            if (vec[i].v) chk("tbl_m_data", s_d, vec[i].d);
        end
        // back-pressure: at most two reads, A0 held
        for (int i = 0; i < 5; i++) src.push_back(DW'(8'hA0 + i));
        r0 = nread;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0);
            step();
            if (i >= 2) begin
                chk("bp_m_valid", s_v, 1);
                chk("bp_m_data", s_d, 8'hA0);
            end
        end
        chk("bp_reads", nread - r0, 2);
        run_until(5, 30, 1'b0);
        chk("bp_drained", exp_q.size(), 0);
        // random back-pressure and empty gaps
        for (int i = 0; i < 1000; i++) src.push_back(DW'($urandom));
        run_until(1000, 20000, 1'b1);
        chk("rand_drained", exp_q.size(), 0);
        // reset with a buffered word and a read in flight
        for (int i = 0; i < 4; i++) src.push_back(DW'(8'hC0 + i));
        drive(1'b0, 1'b0);
        step();
        step();
        chk("pre_rst_valid", bus.m_valid, 1);
        do_reset();
        drive(1'b1, 1'b1);
        step();
        chk("no_stale_valid", s_v, 0);
        src.push_back(8'h5A);
        src.push_back(8'h5B);
        run_until(2, 20, 1'b0);
`ifdef RD_STREAM_STATS_EN
        do_reset();
        for (int i = 0; i < 20; i++) src.push_back(DW'(i));
        r0 = npop;
        for (int c = 0; c < 100 && npop - r0 < 20; c++) begin
            drive(1'b0, stalls >= 3);
            step();
        end
        chk("stats_pops", npop - r0, 20);
        chk("xfer_cnt_sat", xfer_cnt, (xfers > 15) ? 15 : xfers);
        chk("stall_cnt", stall_cnt, stalls);
        chk("stall_model", stalls, 3);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
